// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect selection and the IF/ID
// pipeline register, plus saturating stall/flush event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PC_WriteEn,
    input  logic             IFID_WriteEn,
    input  logic             IF_flush,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             bne,
    input  logic [31:0]      branch_target,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      IFID_PC4,
    output logic [31:0]      IFID_Instr,
    output logic             IFID_Valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc4;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      ifpc4_q, ifpc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    assign pc4 = pc_q + 32'd4;

    // Redirects can be requested together; jr wins, then bne, then jump.
    always_comb begin
        pc_d = pc_q;
        if (PC_WriteEn) begin
            priority case (1'b1)
                jr:      pc_d = {jr_target[31:2], 2'b00};
                bne:     pc_d = {branch_target[31:2], 2'b00};
                jump:    pc_d = {jump_target[31:2], 2'b00};
                default: pc_d = pc4;
            endcase
        end
    end

    always_comb begin
        instr_d = instr_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        if (IF_flush) begin
            instr_d = 32'd0;
            ifpc4_d = 32'd0;
            valid_d = 1'b0;
        end else if (IFID_WriteEn) begin
            instr_d = imem_data;
            ifpc4_d = pc4;
            valid_d = 1'b1;
        end
    end

    // A flush during a stall counts as a flush, not a stall.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (IF_flush) begin
            if (flush_q != CNT_MAX) flush_d = flush_q + CNT_ONE;
        end else if (!IFID_WriteEn) begin
            if (stall_q != CNT_MAX) stall_d = stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            ifpc4_q <= 32'd0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imem_addr   = pc_q;
    assign IFID_Instr  = instr_q;
    assign IFID_PC4    = ifpc4_q;
    assign IFID_Valid  = valid_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF state;
// a second instance with 2-bit counters exercises saturation.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_WriteEn, IFID_WriteEn, IF_flush;
    logic        jump, bne, jr;
    logic [31:0] jump_target, branch_target, jr_target;
    logic [31:0] imem_addr, imem_data, IFID_PC4, IFID_Instr;
    logic        IFID_Valid;
    logic [15:0] stall_count, flush_count;
    logic [31:0] imem_addr2, imem_data2, IFID_PC4_2, IFID_Instr_2;
    logic        IFID_Valid_2;
    logic [1:0]  stall_count2, flush_count2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        int          stall;
        int          flush;
        int          stall2;
        int          flush2;
    } exp_t;

    exp_t m;
    exp_t q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    assign imem_data  = imem_f(imem_addr);
    assign imem_data2 = imem_f(imem_addr2);

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .IF_flush(IF_flush),
        .jump(jump), .jump_target(jump_target),
        .bne(bne), .branch_target(branch_target),
        .jr(jr), .jr_target(jr_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .IFID_PC4(IFID_PC4), .IFID_Instr(IFID_Instr),
        .IFID_Valid(IFID_Valid),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .IF_flush(IF_flush),
        .jump(jump), .jump_target(jump_target),
        .bne(bne), .branch_target(branch_target),
        .jr(jr), .jr_target(jr_target),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .IFID_PC4(IFID_PC4_2), .IFID_Instr(IFID_Instr_2),
        .IFID_Valid(IFID_Valid_2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic clear_ctl();
        PC_WriteEn = 1'b1; IFID_WriteEn = 1'b1; IF_flush = 1'b0;
        jump = 1'b0; bne = 1'b0; jr = 1'b0;
        jump_target = 32'h0; branch_target = 32'h0; jr_target = 32'h0;
    endtask

    // Predict next state from the current inputs, push, clock, pop, compare.
    task automatic step();
        exp_t e;
        logic [31:0] npc;
        e = m;
        if (reset) begin
            e.pc = 32'h0; e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
            e.stall = 0; e.flush = 0; e.stall2 = 0; e.flush2 = 0;
        end else begin
            if (jr)        npc = jr_target & 32'hFFFF_FFFC;
            else if (bne)  npc = branch_target & 32'hFFFF_FFFC;
            else if (jump) npc = jump_target & 32'hFFFF_FFFC;
            else           npc = m.pc + 32'd4;
            if (PC_WriteEn) e.pc = npc;
            if (IF_flush) begin
                e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
                e.flush  = sat(m.flush, 65535);
                e.flush2 = sat(m.flush2, 3);
            end else if (IFID_WriteEn) begin
                e.instr = imem_f(m.pc); e.pc4 = m.pc + 32'd4; e.valid = 1'b1;
            end else begin
                e.stall  = sat(m.stall, 65535);
                e.stall2 = sat(m.stall2, 3);
            end
        end
        q.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("pc", imem_addr, e.pc);
        chk("instr", IFID_Instr, e.instr);
        chk("pc4", IFID_PC4, e.pc4);
        chk("valid", {31'b0, IFID_Valid}, {31'b0, e.valid});
        chk("stall", {16'b0, stall_count}, 32'(e.stall));
        chk("flush", {16'b0, flush_count}, 32'(e.flush));
        chk("stall2", {30'b0, stall_count2}, 32'(e.stall2));
        chk("flush2", {30'b0, flush_count2}, 32'(e.flush2));
    endtask

    initial begin
        m = '{default: 0};
        clear_ctl();
        reset = 1'b1;
        #2;
        step();
        step();
        chk("rst_valid", {31'b0, IFID_Valid}, 32'h0);
        reset = 1'b0;
        chk("rst_addr", imem_addr, 32'h0);

        // sequential fetch
        step();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_pc4_4", IFID_PC4, 32'h4);
        step();
        chk("seq_addr8", imem_addr, 32'h8);

        // load-use stall at PC=8
        PC_WriteEn = 1'b0; IFID_WriteEn = 1'b0;
        step();
        step();
        chk("stall_pc", imem_addr, 32'h8);
        chk("stall_cnt", {16'b0, stall_count}, 32'd2);
        chk("stall_instr", IFID_Instr, imem_f(32'h4));
        clear_ctl();
        step();
        chk("resume_addr", imem_addr, 32'hC);
        step();

        // redirect priority with flush
        jr = 1'b1; bne = 1'b1; jump = 1'b1; IF_flush = 1'b1;
        jr_target = 32'h100; branch_target = 32'h200; jump_target = 32'h300;
        step();
        chk("redir_pc", imem_addr, 32'h100);
        chk("redir_bubble", {31'b0, IFID_Valid}, 32'h0);
        clear_ctl();
        step();
        chk("redir_pc4", IFID_PC4, 32'h104);

        // bne over jump
        bne = 1'b1; jump = 1'b1;
        branch_target = 32'h0000_0442; jump_target = 32'h300;
        step();
        chk("bne_pc", imem_addr, 32'h440);
        clear_ctl();

        // alignment
        jump = 1'b1; jump_target = 32'h0000_0203;
        step();
        chk("align_pc", imem_addr, 32'h200);

        // redirect while PC held
        PC_WriteEn = 1'b0; jump_target = 32'h800;
        step();
        chk("hold_redir", imem_addr, 32'h200);
        clear_ctl();

        // wrap
        jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        step();
        clear_ctl();
        step();
        chk("wrap_pc", imem_addr, 32'h0);
        chk("wrap_pc4", IFID_PC4, 32'h0);

        // flush during stall
        IF_flush = 1'b1; IFID_WriteEn = 1'b0; PC_WriteEn = 1'b0;
        step();
        chk("fs_instr", IFID_Instr, 32'h0);
        chk("fs_pc", imem_addr, 32'h0);
        clear_ctl();
        step();

        // saturation of 2-bit counters
        PC_WriteEn = 1'b0; IFID_WriteEn = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("sat_stall2", {30'b0, stall_count2}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            IF_flush = 1'b1;
            step();
        end
        chk("sat_flush2", {30'b0, flush_count2}, 32'd3);

        // reset mid-stall and mid-redirect
        IF_flush = 1'b0; jump = 1'b1; jump_target = 32'h900;
        reset = 1'b1;
        step();
        chk("rst_mid_pc", imem_addr, 32'h0);
        chk("rst_mid_stall", {16'b0, stall_count}, 32'h0);
        reset = 1'b0;
        clear_ctl();

        // randomized control mix
        for (int i = 0; i < 40; i++) begin
            PC_WriteEn    = ($urandom_range(0, 3) != 0);
            IFID_WriteEn  = ($urandom_range(0, 3) != 0);
            IF_flush      = ($urandom_range(0, 4) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            bne           = ($urandom_range(0, 5) == 0);
            jr            = ($urandom_range(0, 7) == 0);
            jump_target   = $urandom;
            branch_target = $urandom;
            jr_target     = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, 16, width of the stall and flush event counters.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PC_WriteEn  input  1  1 = PC may update; 0 = PC holds (load-use stall).
REQ-006 IFID_WriteEn  input  1  1 = IF/ID register loads; 0 = IF/ID holds.
REQ-007 IF_flush  input  1  1 = squash instruction being fetched (redirect).
REQ-008 jump  input  1  unconditional jump redirect request.
REQ-009 jump_target  input  32  jump destination.
REQ-010 bne  input  1  taken-branch redirect request.
REQ-011 branch_target  input  32  branch destination.
REQ-012 jr  input  1  register-jump redirect request.
REQ-013 jr_target  input  32  register-jump destination.
REQ-014 imem_addr  output  32  instruction memory address, equal to current PC.
REQ-015 imem_data  input  32  instruction word, combinational read of imem_addr in the same cycle.
REQ-016 IFID_PC4  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-017 IFID_Instr  output  32  registered instruction word.
REQ-018 IFID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-019 stall_count  output  CNT_W  count of IF/ID hold cycles.
REQ-020 flush_count  output  CNT_W  count of IF/ID flush cycles.

Function
REQ-021 PC is a 32-bit register; imem_addr SHALL equal PC combinationally.
REQ-022 next-PC priority: jr -> jr_target; else bne -> branch_target; else jump -> jump_target; else PC+4.
REQ-023 Selected target bits [1:0] SHALL be forced to 2'b00 (word alignment); bits [31:2] unchanged.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 PC SHALL load next-PC on a clock edge only when PC_WriteEn=1; PC_WriteEn=0 holds PC, including when a redirect is requested.
REQ-026 IF/ID update, in priority order: IF_flush=1 -> IFID_Instr=0, IFID_PC4=0, IFID_Valid=0; else IFID_WriteEn=1 -> IFID_Instr=imem_data, IFID_PC4=PC+4, IFID_Valid=1; else hold all three.
REQ-027 IF_flush SHALL take precedence over IFID_WriteEn=0 (simultaneous flush and stall produces a bubble).
REQ-028 Latency: instruction at PC appears on IFID_Instr one cycle after the edge at which PC was presented, with no flush and IFID_WriteEn=1.
REQ-029 A redirect SHALL produce exactly one bubble in IF/ID when IF_flush is asserted with it; the target instruction enters IF/ID on the following edge.
REQ-030 stall_count SHALL increment by 1 on each edge with IFID_WriteEn=0 and IF_flush=0, saturating at 2^CNT_W-1.
REQ-031 flush_count SHALL increment by 1 on each edge with IF_flush=1, saturating at 2^CNT_W-1.
REQ-032 No internal state machine beyond PC, IF/ID and counters; outputs depend only on registered state, except imem_addr.

Reset
REQ-033 On an edge with reset=1: PC=RESET_PC, IFID_Instr=0, IFID_PC4=0, IFID_Valid=0, stall_count=0, flush_count=0.
REQ-034 reset SHALL override all other inputs, including mid-stall and mid-redirect.
REQ-035 First cycle after reset deasserts: imem_addr=RESET_PC; IFID_Valid rises on the next edge if IFID_WriteEn=1 and IF_flush=0.

Verification
REQ-036 Sequential fetch: reset, imem returns addr-derived words, all enables 1 for 4 cycles -> imem_addr 0,4,8,C; IFID_PC4 4,8,C lagging one cycle; IFID_Valid=1 from cycle 2.
REQ-037 Load-use stall: PC_WriteEn=0, IFID_WriteEn=0 for 2 cycles at PC=8 -> PC stays 8, IFID_Instr unchanged, stall_count=2, fetch resumes at C.
REQ-038 Redirect priority: jr=bne=jump=1, targets 0x100/0x200/0x300, IF_flush=1 -> PC=0x100, IFID_Valid=0, flush_count+1; next edge IFID_PC4=0x104.
REQ-039 Alignment and wrap: jump_target=0x0000_0203 -> PC=0x200; PC=0xFFFF_FFFC sequential -> next PC=0.
REQ-040 Flush during stall: IF_flush=1, IFID_WriteEn=0, PC_WriteEn=0 -> IFID_Valid=0, IFID_Instr=0, PC held, flush_count+1, stall_count unchanged.
REQ-041 Reset mid-operation and saturation: reset during stall -> all outputs to reset values next edge; CNT_W=2 with 5 stall cycles -> stall_count=3.
